// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: fetch state enum, opcode constants, default PC width
package cpu_pkg;

  localparam int DEFAULT_PC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetchState_e;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_ADDSUB = 4'b0001;
  localparam logic [3:0] OP_SHIFT  = 4'b0010;
  localparam logic [3:0] OP_ADDI   = 4'b1001;
  localparam logic [3:0] OP_SUBI   = 4'b1010;
  localparam logic [3:0] OP_SLTI   = 4'b1011;
  localparam logic [3:0] OP_LW     = 4'b1100;
  localparam logic [3:0] OP_SW     = 4'b1101;
  localparam logic [3:0] OP_BEQ    = 4'b1111;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction-memory request/acknowledge bus
interface instruction_fetch_if #(
  parameter int PC_WIDTH = 16
);
  logic                IMemReq;
  logic [PC_WIDTH-1:0] IMemAddr;
  logic                IMemAck;
  logic [15:0]         IMemData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemData
  );
endinterface

// File: rtl/instruction_fetch_pc_next.sv
// rtl/instruction_fetch_pc_next.sv - combinational next-PC selection (sequential or taken BEQ)
module pc_next #(
  parameter int PC_WIDTH = 16
) (
  input  logic [PC_WIDTH-1:0] PC,
  input  logic [PC_WIDTH-1:0] BranchImm,
  input  logic                Branch,
  input  logic                Zero,
  output logic [PC_WIDTH-1:0] PCPlus2,
  output logic [PC_WIDTH-1:0] NextPC
);

  logic [PC_WIDTH-1:0] byteOffset;
  // The offset is in words; its MSB falls off the top when scaled to bytes.
  logic                unusedImmMsb;

  assign unusedImmMsb = BranchImm[PC_WIDTH-1];
  assign byteOffset   = {BranchImm[PC_WIDTH-2:0], 1'b0};

  // Sequential and branch targets both wrap modulo 2^PC_WIDTH.
  always_comb begin
    PCPlus2 = PC + PC_WIDTH'(2);
    NextPC  = PCPlus2;
    if (Branch && Zero) begin
      NextPC = PCPlus2 + byteOffset;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage FSM; optional fetch timeout under IF_TIMEOUT_EN
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH       = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
  parameter logic [7:0]          TIMEOUT_CYCLES = 8'd16
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Stall,
  input  logic                 Branch,
  input  logic                 Zero,
  input  logic [PC_WIDTH-1:0]  BranchImm,
  instruction_fetch_if.master  imem,
  output logic [15:0]          Instruction,
  output logic [3:0]           OPCODE,
  output logic                 InstrValid,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [PC_WIDTH-1:0]  PCPlus2,
  output logic                 FetchError
);

  fetchState_e         state;
  logic [PC_WIDTH-1:0] pcReg;
  logic [PC_WIDTH-1:0] nextPc;
  logic [15:0]         instrReg;
  logic                validReg;
  logic                reqReg;

  pc_next #(.PC_WIDTH(PC_WIDTH)) uPcNext (
    .PC        (pcReg),
    .BranchImm (BranchImm),
    .Branch    (Branch),
    .Zero      (Zero),
    .PCPlus2   (PCPlus2),
    .NextPC    (nextPc)
  );

  assign PC            = pcReg;
  assign Instruction   = instrReg;
  assign OPCODE        = instrReg[15:12];
  assign InstrValid    = validReg;
  assign imem.IMemReq  = reqReg;
  assign imem.IMemAddr = pcReg;

`ifdef IF_TIMEOUT_EN
  logic [7:0] timeoutCnt;
  logic       errReg;
  logic       timeoutHit;

  assign timeoutHit = (state == FETCH) && reqReg && !imem.IMemAck &&
                      (timeoutCnt == TIMEOUT_CYCLES - 8'd1);
  assign FetchError = errReg;

  // Count unacknowledged request cycles; on expiry flag the error and restart the count.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      timeoutCnt <= 8'd0;
      errReg     <= 1'b0;
    end else if (state != FETCH || !reqReg || imem.IMemAck) begin
      timeoutCnt <= 8'd0;
    end else if (timeoutHit) begin
      timeoutCnt <= 8'd0;
      errReg     <= 1'b1;
    end else begin
      timeoutCnt <= timeoutCnt + 8'd1;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign FetchError    = 1'b0;
`endif

  // Fetch FSM: request, capture on ack, hold while stalled, then advance PC.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pcReg    <= RESET_PC;
      instrReg <= 16'h0000;
      validReg <= 1'b0;
      reqReg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state  <= FETCH;
          reqReg <= 1'b1;
        end
        FETCH: begin
          if (reqReg && imem.IMemAck) begin
            instrReg <= imem.IMemData;
            validReg <= 1'b1;
            reqReg   <= 1'b0;
            state    <= VALID;
          end
`ifdef IF_TIMEOUT_EN
          // One-cycle request gap after a timeout, then re-request the same address.
          else if (!reqReg) begin
            reqReg <= 1'b1;
          end else if (timeoutHit) begin
            reqReg <= 1'b0;
          end
`endif
        end
        VALID: begin
          if (!Stall) begin
            pcReg    <= nextPc;
            validReg <= 1'b0;
            reqReg   <= 1'b1;
            state    <= FETCH;
          end
        end
        default: begin
          state  <= IDLE;
          reqReg <= 1'b0;
        end
      endcase
    end
  end

endmodule
